bram_tx_buf: RTL

Transmit-side buffer and byte serializer that sits directly downstream of the AXI-lite register block in the bram2udp path. It stores the 32-bit words the register block writes into the send window, and on a send command (SDLEN with start bit set) streams the requested number of bytes, MSB-first, onto a byte-wide valid/ready interface toward the UDP framer. It also generates the transmit completion interrupt and error flags that the register block reports in INT_STATUS and STATUS.

---
 rtl/bram_tx_buf.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/bram_tx_buf.sv
// Transmit buffer for the bram2udp path: collects 32-bit words from the register
// block and serializes a requested number of bytes, MSB first, to the UDP framer.
module bram_tx_buf #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          sclk,
  input  logic          reset_n,
  input  logic          tx_valid_i,
  input  logic [31:0]   tx_data_i,
  input  logic [16:0]   SDLEN_i,
  input  logic          tx_int_enable_i,
  input  logic          int_tx_clear_i,
  input  logic          tx_error_clear_i,
  input  logic          link_success_i,
  output logic [7:0]    m_data_o,
  output logic          m_valid_o,
  output logic          m_last_o,
  input  logic          m_ready_i,
  output logic          INT_tx_o,
  output logic          tx_irq_o,
  output logic          tx_error_o,
  output logic          busy_o,
  output logic [AW:0]   wr_count_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  state_t         state_q, state_d;
  logic [AW:0]    wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [15:0]    bytes_left_q, bytes_left_d;
  logic [1:0]     idx_q, idx_d;
  logic [31:0]    shift_q, shift_d;
  logic           start_hist_q, start_hist_d;
  logic           int_tx_q, int_tx_d;
  logic           irq_q, irq_d;
  logic           err_q, err_d;

  logic [31:0]    mem [DEPTH];
  logic [31:0]    rd_data_q;
  logic           wr_en;
  logic           err_set;
  logic           int_set;
  logic           start_evt;
  logic [17:0]    len_ext;
  logic [17:0]    cap_bytes;
  logic [7:0]     byte_sel;

  // Block RAM: no reset, read data registered every cycle from rptr.
  always_ff @(posedge sclk) begin
    if (wr_en) begin
      mem[wptr_q[AW-1:0]] <= tx_data_i;
    end
    rd_data_q <= mem[rptr_q];
  end

  assign start_evt = SDLEN_i[16] & ~start_hist_q;
  assign len_ext   = {2'b00, SDLEN_i[15:0]};
  assign cap_bytes = 18'({wptr_q, 2'b00});

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    bytes_left_d = bytes_left_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    start_hist_d = SDLEN_i[16];
    wr_en        = 1'b0;
    err_set      = 1'b0;
    int_set      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_valid_i) begin
          if (wptr_q == FULL_COUNT) begin
            err_set = 1'b1;
          end else begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + 1'b1;
          end
        end
        if (start_evt) begin
          if (len_ext == 18'd0 || len_ext > cap_bytes || !link_success_i) begin
            err_set = 1'b1;
          end else begin
            rptr_d       = '0;
            bytes_left_d = SDLEN_i[15:0];
            state_d      = ST_RD;
          end
        end
      end
      ST_RD: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d = rd_data_q;
        idx_d   = 2'd0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (m_ready_i) begin
          bytes_left_d = bytes_left_q - 16'd1;
          if (bytes_left_q == 16'd1) begin
            state_d = ST_DONE;
          end else if (idx_q == 2'd3) begin
            rptr_d  = rptr_q + 1'b1;
            state_d = ST_RD;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        // Buffer is consumed by a send; unsent trailing words are discarded.
        int_set = 1'b1;
        wptr_d  = '0;
        rptr_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (tx_valid_i && state_q != ST_IDLE) begin
      err_set = 1'b1;
    end

    // A set in the same cycle as a clear wins.
    int_tx_d = int_set | (int_tx_q & ~int_tx_clear_i);
    err_d    = err_set | (err_q & ~tx_error_clear_i);
    irq_d    = int_tx_q & tx_int_enable_i;
  end

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      bytes_left_q <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      start_hist_q <= 1'b0;
      int_tx_q     <= 1'b0;
      irq_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      bytes_left_q <= bytes_left_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      start_hist_q <= start_hist_d;
      int_tx_q     <= int_tx_d;
      irq_q        <= irq_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    byte_sel = 8'h00;
    case (idx_q)
      2'd0: byte_sel = shift_q[31:24];
      2'd1: byte_sel = shift_q[23:16];
      2'd2: byte_sel = shift_q[15:8];
      2'd3: byte_sel = shift_q[7:0];
      default: byte_sel = 8'h00;
    endcase
  end

  assign m_valid_o  = (state_q == ST_SEND);
  assign m_data_o   = m_valid_o ? byte_sel : 8'h00;
  assign m_last_o   = m_valid_o & (bytes_left_q == 16'd1);
  assign INT_tx_o   = int_tx_q;
  assign tx_irq_o   = irq_q;
  assign tx_error_o = err_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign wr_count_o = wptr_q;

endmodule
